// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the seq_pattern_det serial pattern detector.
package seq_det_pkg;

  localparam int         DEF_PAT_W   = 4;
  localparam logic [3:0] DEF_PAT_RST = 4'b1011;
  localparam int         DEF_CNT_W   = 8;

  // The fill count must be able to hold the value PAT_W itself, not just PAT_W-1.
  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_pattern_det_if.sv
// Stream, configuration and match-report signals of seq_pattern_det.
interface seq_pattern_det_if
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
);

  logic             clear;
  logic             in_valid;
  logic             in;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic             cfg_overlap;
  logic             out;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output clear, in_valid, in, cfg_load, cfg_pattern, cfg_overlap,
    input  out, match_cnt
  );

  modport slave (
    input  clear, in_valid, in, cfg_load, cfg_pattern, cfg_overlap,
    output out, match_cnt
  );

endinterface

// File: rtl/seq_det_sat_cnt.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module seq_det_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Count register: clear wins over increment, increment stops at full scale.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_pattern_det.sv
// Runtime-loadable serial pattern detector with overlap/non-overlap modes.
// Define SEQ_PATTERN_DET_COUNT_EN to build the saturating match counter.
module seq_pattern_det
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(DEF_PAT_RST),
  parameter int               CNT_W   = DEF_CNT_W
) (
  input logic               clk,
  input logic               reset_n,
  seq_pattern_det_if.slave  sif
);

  localparam int             FW        = fill_w(PAT_W);
  localparam logic [FW-1:0]  FILL_FULL = FW'(PAT_W);

  logic [PAT_W-1:0] r_pat,  w_pat_nx;
  logic [PAT_W-1:0] r_hist, w_hist_nx, w_hist_sh;
  logic [FW-1:0]    r_fill, w_fill_nx, w_fill_sh;
  logic             r_out,  w_out_nx;
  logic             w_accept;
  logic             w_match;

  assign w_accept  = sif.in_valid & ~sif.clear & ~sif.cfg_load;
  assign w_hist_sh = {r_hist[PAT_W-2:0], sif.in};
  assign w_fill_sh = (r_fill == FILL_FULL) ? r_fill : r_fill + {{(FW-1){1'b0}}, 1'b1};
  assign w_match   = w_accept & (w_fill_sh == FILL_FULL) & (w_hist_sh == r_pat);

  // Next-state selection: clear over cfg_load over an accepted bit, otherwise hold.
  always_comb begin
    w_pat_nx  = r_pat;
    w_hist_nx = r_hist;
    w_fill_nx = r_fill;
    w_out_nx  = 1'b0;
    if (sif.clear) begin
      w_hist_nx = {PAT_W{1'b0}};
      w_fill_nx = {FW{1'b0}};
    end else if (sif.cfg_load) begin
      w_pat_nx  = sif.cfg_pattern;
      w_hist_nx = {PAT_W{1'b0}};
      w_fill_nx = {FW{1'b0}};
    end else if (w_accept) begin
      w_hist_nx = w_hist_sh;
      // Non-overlap restarts the fill so the next match needs PAT_W fresh bits.
      w_fill_nx = (w_match && !sif.cfg_overlap) ? {FW{1'b0}} : w_fill_sh;
      w_out_nx  = w_match;
    end else begin
      w_hist_nx = r_hist;
      w_fill_nx = r_fill;
    end
  end

  // Detector state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pat  <= PAT_RST;
      r_hist <= {PAT_W{1'b0}};
      r_fill <= {FW{1'b0}};
      r_out  <= 1'b0;
    end else begin
      r_pat  <= w_pat_nx;
      r_hist <= w_hist_nx;
      r_fill <= w_fill_nx;
      r_out  <= w_out_nx;
    end
  end

  assign sif.out = r_out;

`ifdef SEQ_PATTERN_DET_COUNT_EN
  logic [CNT_W-1:0] w_cnt;

  seq_det_sat_cnt #(.CNT_W(CNT_W)) u_sat_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (sif.clear),
    .i_inc   (w_match),
    .o_cnt   (w_cnt)
  );

  assign sif.match_cnt = w_cnt;
`else
  assign sif.match_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_pattern_det.sv
// Directed self-checking bench for seq_pattern_det (4-bit pattern, 2-bit counter).
module tb_seq_pattern_det;

  localparam int CNT_W = 2;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;
  int   n_match;

  seq_pattern_det_if #(.PAT_W(4), .CNT_W(CNT_W)) sif ();

  seq_pattern_det #(.PAT_W(4), .PAT_RST(4'b1011), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sif     (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef SEQ_PATTERN_DET_COUNT_EN
    return (n > 3) ? 32'd3 : 32'(n);
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk(tag, {30'd0, sif.match_cnt}, exp_cnt(n_match));
  endtask

  // Feed bits MSB first, checking out after each edge against expv.
  task automatic run_seq(input string tag, input logic [15:0] bits,
                         input logic [15:0] expv, input int len);
    for (int i = len - 1; i >= 0; i--) begin
      sif.in_valid = 1'b1;
      sif.in       = bits[i];
      @(posedge clk); #1;
      chk($sformatf("%s[%0d]", tag, len - 1 - i), {31'd0, sif.out}, {31'd0, expv[i]});
    end
    sif.in_valid = 1'b0;
    sif.in       = 1'b0;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk(tag, {31'd0, sif.out}, 32'd0);
    end
  endtask

  // Load a pattern while offering a valid 1, which must be dropped.
  task automatic load(input logic [3:0] p);
    sif.cfg_load    = 1'b1;
    sif.cfg_pattern = p;
    sif.in_valid    = 1'b1;
    sif.in          = 1'b1;
    @(posedge clk); #1;
    chk("load_out", {31'd0, sif.out}, 32'd0);
    sif.cfg_load = 1'b0;
    sif.in_valid = 1'b0;
    sif.in       = 1'b0;
  endtask

  task automatic do_clear();
    sif.clear = 1'b1;
    @(posedge clk); #1;
    sif.clear = 1'b0;
    n_match   = 0;
    chk("clear_out", {31'd0, sif.out}, 32'd0);
    chk_cnt("clear_cnt");
  endtask

  initial begin
    n_cmp = 0; n_err = 0; n_match = 0;
    reset_n         = 1'b0;
    sif.clear       = 1'b0;
    sif.in_valid    = 1'b0;
    sif.in          = 1'b0;
    sif.cfg_load    = 1'b0;
    sif.cfg_pattern = 4'b0000;
    sif.cfg_overlap = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", {31'd0, sif.out}, 32'd0);
    chk_cnt("rst_cnt");
    reset_n = 1'b1;

    // Default pattern 1011 straight after reset.
    run_seq("basic", 16'b1011, 16'b0001, 4);
    n_match = 1;
    chk_cnt("basic_cnt");
    idle("basic_idle", 1);

    // Overlap versus non-overlap on 1011011.
    do_clear();
    run_seq("ovl", 16'b1011011, 16'b0001001, 7);
    n_match = 2;
    chk_cnt("ovl_cnt");
    do_clear();
    sif.cfg_overlap = 1'b0;
    run_seq("novl", 16'b1011011, 16'b0001000, 7);
    n_match = 1;
    chk_cnt("novl_cnt");

    // Pattern 1111: back-to-back pulses, counter kept across load, saturation.
    sif.cfg_overlap = 1'b1;
    load(4'b1111);
    chk_cnt("load_keeps_cnt");
    run_seq("ones_ovl", 16'hFF, 16'b00011111, 8);
    n_match = 6;
    chk_cnt("sat_cnt");
    do_clear();
    sif.cfg_overlap = 1'b0;
    run_seq("ones_novl", 16'hFF, 16'b00010001, 8);
    n_match = 2;
    chk_cnt("ones_novl_cnt");

    // Gaps are transparent; a load between bits restarts detection.
    load(4'b1011);
    do_clear();
    sif.cfg_overlap = 1'b1;
    run_seq("gap_a", 16'b10, 16'b00, 2);
    idle("gap_idle", 3);
    run_seq("gap_b", 16'b11, 16'b01, 2);
    n_match = 1;
    chk_cnt("gap_cnt");
    run_seq("ldmid_a", 16'b10, 16'b00, 2);
    load(4'b1011);
    run_seq("ldmid_b", 16'b11, 16'b00, 2);
    chk_cnt("ldmid_cnt");

    // Asynchronous reset mid-pattern restores pattern 1011 and empties history.
    load(4'b1100);
    run_seq("prerst", 16'b101, 16'b000, 3);
    reset_n = 1'b0;
    #1;
    n_match = 0;
    chk("midrst_out", {31'd0, sif.out}, 32'd0);
    chk_cnt("midrst_cnt");
    @(negedge clk);
    reset_n = 1'b1;
    run_seq("postrst", 16'b1011, 16'b0001, 4);
    n_match = 1;
    chk_cnt("postrst_cnt");

    // All-zero pattern: cleared history must not match before fill is full.
    load(4'b0000);
    run_seq("zeros", 16'b0000, 16'b0001, 4);
    n_match = 2;
    chk_cnt("zeros_cnt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
